// File: rtl/servo_pkg.sv
// servo_pkg: timing defaults, position type and decoder FSM states shared with the ADC-to-servo path
package servo_pkg;
    localparam int PULSE_MIN_CYC_DEF     = 50000;
    localparam int PULSE_MAX_CYC_DEF     = 100000;
    localparam int FRAME_TIMEOUT_CYC_DEF = 1500000;
    typedef logic [11:0] pos_t;
    typedef enum logic [1:0] {ST_ARM, ST_WAIT_RISE, ST_MEASURE, ST_DIVIDE} state_e;
endpackage

// File: rtl/servo_div_u.sv
// servo_div_u: fixed 12-cycle restoring divider for quotients known to fit in 12 bits
module servo_div_u (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [27:0] i_num,
    input  logic [15:0] i_den,
    output logic        o_busy,
    output logic        o_done,
    output logic [11:0] o_quot
);
    logic [15:0] r_rem;
    logic [11:0] r_q;
    logic [3:0]  r_cnt;
    logic [16:0] w_sh;
    logic [15:0] w_diff;
    logic        w_ge;
    // quotient < 4096 guarantees i_num[27:12] < i_den, so it seeds the remainder directly
    assign w_sh   = {r_rem, r_q[11]};
    assign w_ge   = w_sh >= {1'b0, i_den};
    assign w_diff = 16'(w_sh - {1'b0, i_den});
    assign o_quot = r_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start && !o_busy) begin
                r_rem  <= i_num[27:12];
                r_q    <= i_num[11:0];
                r_cnt  <= '0;
                o_busy <= 1'b1;
            end else if (o_busy) begin
                r_rem <= w_ge ? w_diff : w_sh[15:0];
                r_q   <= {r_q[10:0], w_ge};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd11) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM high time and maps it to a 12-bit position
// SERVO_DEC_GLITCH_FILTER_EN adds a 4-cycle stability filter on the synchronized input
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int PULSE_MIN_CYC     = PULSE_MIN_CYC_DEF,
    parameter int PULSE_MAX_CYC     = PULSE_MAX_CYC_DEF,
    parameter int FRAME_TIMEOUT_CYC = FRAME_TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output pos_t        pos_out,
    output logic        pos_valid,
    output logic [16:0] width_cyc,
    output logic        range_err,
    output logic        signal_lost
);
    localparam int              CW      = $clog2(FRAME_TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   TO_END  = CW'(FRAME_TIMEOUT_CYC);
    localparam logic [CW-1:0]   TO_LAST = CW'(FRAME_TIMEOUT_CYC - 1);
    localparam logic [16:0]     MIN17   = 17'(PULSE_MIN_CYC);
    localparam logic [16:0]     MAX17   = 17'(PULSE_MAX_CYC);
    localparam logic [15:0]     DEN     = 16'(PULSE_MAX_CYC - PULSE_MIN_CYC);
    logic r_s1, r_s2, r_d, r_rise, r_fall, w_in;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam logic [CW-1:0] FILL = CW'(8);
    logic       r_filt;
    logic [1:0] r_fcnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (r_s2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == 2'd3) begin
            r_filt <= r_s2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 2'd1;
        end
    end
    assign w_in = r_filt;
`else
    localparam logic [CW-1:0] FILL = CW'(4);
    assign w_in = r_s2;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_s1, r_s2, r_d, r_rise, r_fall} <= '0;
        end else begin
            r_s1   <= pwm_in;
            r_s2   <= r_s1;
            r_d    <= w_in;
            r_rise <= w_in & ~r_d;
            r_fall <= ~w_in & r_d;
        end
    end
    logic [CW-1:0] r_to_cnt;
    logic          w_to_hit;
    assign w_to_hit = ~r_rise & (r_to_cnt == TO_LAST);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt    <= '0;
            signal_lost <= 1'b0;
        end else begin
            r_to_cnt    <= r_rise ? '0 : (r_to_cnt == TO_END ? r_to_cnt : r_to_cnt + CW'(1));
            signal_lost <= r_rise ? 1'b0 : (signal_lost | w_to_hit);
        end
    end
    state_e      r_state;
    logic [16:0] r_cnt, w_clamp;
    logic [15:0] r_x, w_x;
    logic [27:0] r_num;
    logic        r_err, r_prep, r_start, w_lo, w_hi, w_busy, w_done;
    pos_t        w_q;
    assign w_lo    = r_cnt < MIN17;
    assign w_hi    = r_cnt > MAX17;
    assign w_clamp = w_lo ? MIN17 : (w_hi ? MAX17 : r_cnt);
    assign w_x     = 16'(w_clamp - MIN17);
    // ARM also waits for the reset-cleared input pipeline to refill so a pulse in progress is not mistaken for low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_ARM;
            r_cnt     <= '0;
            r_x       <= '0;
            r_num     <= '0;
            r_err     <= 1'b0;
            r_prep    <= 1'b0;
            r_start   <= 1'b0;
            pos_out   <= '0;
            pos_valid <= 1'b0;
            width_cyc <= '0;
            range_err <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            r_prep    <= 1'b0;
            r_start   <= r_prep & ~w_busy;
            if (r_prep) r_num <= {r_x, 12'd0} - {12'd0, r_x};
            case (r_state)
                ST_ARM: if (!r_d && r_to_cnt > FILL) r_state <= ST_WAIT_RISE;
                ST_WAIT_RISE: if (r_rise) begin
                    r_state <= ST_MEASURE;
                    r_cnt   <= 17'd1;
                end
                ST_MEASURE: if (w_to_hit) begin
                    r_state <= ST_ARM;
                end else if (r_fall) begin
                    r_state <= ST_DIVIDE;
                    r_x     <= w_x;
                    r_err   <= w_lo | w_hi;
                    r_prep  <= 1'b1;
                end else if (r_d && r_cnt != '1) begin
                    r_cnt <= r_cnt + 17'd1;
                end
                ST_DIVIDE: if (w_done) begin
                    r_state   <= ST_WAIT_RISE;
                    pos_valid <= 1'b1;
                    pos_out   <= w_q;
                    width_cyc <= r_cnt;
                    range_err <= r_err;
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end
    servo_div_u u_div (
        .clk     (clk),
        .reset   (reset),
        .i_start (r_start),
        .i_num   (r_num),
        .i_den   (DEN),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_quot  (w_q)
    );
endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose the following parameters (name, default, meaning):
- PULSE_MIN_CYC, 50000, 1.0 ms pulse at 50 MHz, maps to position 0.
- PULSE_MAX_CYC, 100000, 2.0 ms pulse, maps to position 4095.
- FRAME_TIMEOUT_CYC, 1500000, 30 ms with no rising edge means signal lost.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- pwm_in, in, 1, asynchronous servo PWM input.
- pos_out, out, 12, decoded position 0..4095.
- pos_valid, out, 1, one-cycle strobe; pos_out, width_cyc and range_err are valid on it.
- width_cyc, out, 17, measured high time in clk cycles, saturating at 131071.
- range_err, out, 1, last pulse fell outside [PULSE_MIN_CYC, PULSE_MAX_CYC].
- signal_lost, out, 1, level; no rising edge seen for FRAME_TIMEOUT_CYC cycles.

Function
REQ-004 pwm_in SHALL pass through a 2-flop synchronizer before edge detection.
REQ-005 The FSM SHALL have states ARM, WAIT_RISE, MEASURE, DIVIDE, and SHALL enter ARM on reset.
REQ-006 ARM SHALL move to WAIT_RISE only after the synchronized input is sampled low, so a pulse already in progress is discarded.
REQ-007 On a rising edge in WAIT_RISE, the FSM SHALL move to MEASURE and load the width counter with 1.
- In MEASURE, the counter increments each cycle the input is high.
- The counter saturates at 131071.
REQ-008 On a falling edge in MEASURE, the FSM SHALL:
- latch width_cyc;
- clamp it to [PULSE_MIN_CYC, PULSE_MAX_CYC];
- set the range_err result if clamping occurred;
- enter DIVIDE.
REQ-009 Position SHALL equal floor((clamped − PULSE_MIN_CYC) × 4095 / (PULSE_MAX_CYC − PULSE_MIN_CYC)).
- The ×4095 term is formed as (x<<12) − x, with no hardware multiplier.
- The quotient comes from a 12-iteration restoring divider.
REQ-010 pos_valid SHALL pulse exactly 18 cycles after the first clk edge that samples pwm_in low at the pin.
- On that same cycle, pos_out, width_cyc and range_err update.
- The FSM then returns to WAIT_RISE.
REQ-011 pos_out, width_cyc and range_err SHALL hold their values between strobes.
REQ-012 Edges arriving during DIVIDE SHALL be ignored, and that pulse SHALL NOT produce a strobe.
REQ-013 The timeout counter SHALL clear on every synchronized rising edge.
- signal_lost sets when the counter reaches FRAME_TIMEOUT_CYC, including while stuck high in MEASURE.
- Entering signal_lost from MEASURE forces the FSM to ARM without a strobe.
- signal_lost clears on the next rising edge.
REQ-014 If a rising edge and the timeout terminal count occur in the same cycle, the edge SHALL win and signal_lost SHALL stay 0.

Reset
REQ-015 Reset SHALL drive the following values:
- pos_out=0, pos_valid=0, width_cyc=0, range_err=0, signal_lost=0.
- FSM=ARM; all counters, synchronizer flops and divider registers cleared.
REQ-016 Reset asserted mid-pulse or mid-divide SHALL abort the operation, and no strobe SHALL follow for that pulse.

Configuration
REQ-017 When SERVO_DEC_GLITCH_FILTER_EN is defined, a change on the synchronized input SHALL be accepted only after it is stable for 4 consecutive cycles.
- Shorter glitches are ignored.
- The REQ-010 latency becomes 22 cycles.
- Measured width is unchanged for clean pulses.
REQ-018 When SERVO_DEC_GLITCH_FILTER_EN is undefined, no filter logic SHALL exist and the latency SHALL be 18 cycles.

Structure
REQ-019 Package servo_pkg SHALL hold the following, shared with the ADC-to-servo path:
- PULSE_MIN_CYC, PULSE_MAX_CYC and FRAME_TIMEOUT_CYC defaults;
- the 12-bit position typedef;
- the FSM state enum.
REQ-020 The restoring divider SHALL be a sub-module named servo_div_u.
- Ports: start/busy/done, 28-bit numerator, 16-bit denominator, 12-bit quotient.
- Fixed 12 cycles.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- 75000-cycle pulse → width_cyc=75000, pos_out=2047, range_err=0, pos_valid exactly 18 cycles after the fall.
- 50000-cycle pulse → pos_out=0; 100000-cycle pulse → pos_out=4095; both with range_err=0.
- 25000-cycle pulse → pos_out=0, range_err=1; 125000-cycle pulse → pos_out=4095, range_err=1, width_cyc=125000.
- Input low for 1500000 cycles → signal_lost=1 at that cycle; next 75000-cycle pulse → signal_lost=0 and pos_out=2047.
- Reset deasserted with pwm_in high mid-pulse → no strobe for that pulse; the following 60000-cycle pulse → pos_out=819.
- With SERVO_DEC_GLITCH_FILTER_EN, 2-cycle low glitch inside a 75000-cycle pulse → single strobe, pos_out=2047, latency 22 cycles.
